// File: rtl/rockets_pkg.sv
// Shared constants and state encoding for the rocket motion engines.
// Fixed-point Y uses FP_SHIFT fractional bits (1/64 pixel).
package rockets_pkg;

  localparam int FP_SHIFT         = 6;
  localparam int SCREEN_TOP_PX    = 0;
  localparam int SCREEN_BOTTOM_PX = 479;
  localparam int ROCKET_HEIGHT_PX = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } rocket_state_t;

endpackage

// File: rtl/single_rocket_mover.sv
// Per-rocket vertical motion engine: launches on a rising isActive edge, integrates
// speed once per frame in 1/64-pixel fixed point and pulses reachedBorder on exit.
module single_rocket_mover
  import rockets_pkg::*;
#(
  parameter int ROCKET_HEIGHT = ROCKET_HEIGHT_PX,
  parameter int SCREEN_TOP    = SCREEN_TOP_PX,
  parameter int SCREEN_BOTTOM = SCREEN_BOTTOM_PX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               isActive,
  input  logic signed [8:0]  initialSpeed,
  input  logic signed [10:0] initialX,
  input  logic signed [10:0] initialY,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               visible,
  output logic               reachedBorder
);

  rocket_state_t      state_q;
  logic signed [16:0] yfp_q;
  logic signed [10:0] xpix_q;
  logic signed [8:0]  speed_q;
  logic               is_active_d_q;
  logic               reached_border_q;

  logic               launch;
  logic signed [16:0] next_fp;
  logic signed [10:0] next_y;
  logic               exit_border;

  always_comb begin
    launch      = isActive & ~is_active_d_q;
    next_fp     = yfp_q + {{8{speed_q[8]}}, speed_q};
    // Slicing off the fraction of a two's-complement value is a floor, not a truncation toward zero.
    next_y      = next_fp[16:FP_SHIFT];
    exit_border = (int'(next_y) < SCREEN_TOP) ||
                  (int'(next_y) + ROCKET_HEIGHT - 1 > SCREEN_BOTTOM);
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      yfp_q            <= '0;
      xpix_q           <= '0;
      speed_q          <= '0;
      is_active_d_q    <= 1'b0;
      reached_border_q <= 1'b0;
    end else begin
      is_active_d_q    <= isActive;
      reached_border_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            xpix_q  <= initialX;
            yfp_q   <= {initialY, {FP_SHIFT{1'b0}}};
            speed_q <= initialSpeed;
            state_q <= FLYING;
          end
        end
        FLYING: begin
          // An abort outranks a frame tick arriving in the same cycle.
          if (!isActive) begin
            state_q <= IDLE;
          end else if (startOfFrame) begin
            if (exit_border) begin
              reached_border_q <= 1'b1;
              state_q          <= IDLE;
            end else begin
              yfp_q <= next_fp;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign topLeftX      = xpix_q;
  assign topLeftY      = yfp_q[16:FP_SHIFT];
  assign visible       = (state_q == FLYING);
  assign reachedBorder = reached_border_q;

endmodule

// File: tb/tb_single_rocket_mover.sv
// Scoreboard bench for single_rocket_mover: each step pushes its expected outputs,
// drives one clock, then the scenario task pops and compares against the DUT.
module tb_single_rocket_mover;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               isActive = 1'b0;
  logic signed [8:0]  initialSpeed = '0;
  logic signed [10:0] initialX = '0;
  logic signed [10:0] initialY = '0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               visible;
  logic               reachedBorder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit sof; bit act; bit rst;
    int ix;  int iy;  int ispd;
    int ex;  int ey;  bit evis; bit erb;
  } step_t;

  typedef struct {
    int x; int y; bit vis; bit rb;
  } exp_t;

  exp_t sb[$];

  single_rocket_mover #(
    .ROCKET_HEIGHT(16),
    .SCREEN_TOP   (0),
    .SCREEN_BOTTOM(479)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .isActive     (isActive),
    .initialSpeed (initialSpeed),
    .initialX     (initialX),
    .initialY     (initialY),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .visible      (visible),
    .reachedBorder(reachedBorder)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(bit sof, bit act, bit rst, int ix, int iy, int ispd,
                               int ex, int ey, bit evis, bit erb);
    step_t s;
    s.sof = sof; s.act = act; s.rst = rst;
    s.ix = ix; s.iy = iy; s.ispd = ispd;
    s.ex = ex; s.ey = ey; s.evis = evis; s.erb = erb;
    return s;
  endfunction

  // Push the expectation, apply the inputs for one edge, settle 1 time unit past it.
  task automatic drive(input step_t s);
    exp_t e;
    e.x = s.ex; e.y = s.ey; e.vis = s.evis; e.rb = s.erb;
    sb.push_back(e);
    reset        = s.rst;
    startOfFrame = s.sof;
    isActive     = s.act;
    initialX     = 11'(s.ix);
    initialY     = 11'(s.iy);
    initialSpeed = 9'(s.ispd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 1, 1, 9, 9, 9, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      checks++;
      if (int'(topLeftX) !== e.x || int'(topLeftY) !== e.y || visible !== e.vis || reachedBorder !== e.rb) begin
        errors++;
        $display("FAIL reset[%0d]: got x=%0d y=%0d vis=%b rb=%b, want x=%0d y=%0d vis=%b rb=%b",
                 i, topLeftX, topLeftY, visible, reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask

  task automatic test_launch_and_move();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 300, 400, -128, 300, 400, 1, 0));
    st.push_back(mk(0, 1, 0,   5,   9,    0, 300, 400, 1, 0)); // re-fire while flying is ignored
    st.push_back(mk(1, 1, 0,   5,   9,    0, 300, 398, 1, 0));
    st.push_back(mk(0, 1, 0,   5,   9,    0, 300, 398, 1, 0));
    st.push_back(mk(1, 1, 0,   5,   9,    0, 300, 396, 1, 0));
    st.push_back(mk(0, 0, 0,   5,   9,    0, 300, 396, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      checks++;
      if (int'(topLeftX) !== e.x || int'(topLeftY) !== e.y || visible !== e.vis || reachedBorder !== e.rb) begin
        errors++;
        $display("FAIL launch_move[%0d]: got x=%0d y=%0d vis=%b rb=%b, want x=%0d y=%0d vis=%b rb=%b",
                 i, topLeftX, topLeftY, visible, reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask

  task automatic test_top_border();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 10, 3, -128, 10, 3, 1, 0));
    st.push_back(mk(1, 1, 0, 10, 3, -128, 10, 1, 1, 0));
    st.push_back(mk(0, 1, 0, 10, 3, -128, 10, 1, 1, 0));
    st.push_back(mk(1, 1, 0, 10, 3, -128, 10, 1, 0, 1));
    st.push_back(mk(0, 1, 0, 10, 3, -128, 10, 1, 0, 0));
    st.push_back(mk(1, 1, 0, 10, 3, -128, 10, 1, 0, 0)); // held high: no relaunch
    st.push_back(mk(0, 0, 0, 10, 3, -128, 10, 1, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      checks++;
      if (int'(topLeftX) !== e.x || int'(topLeftY) !== e.y || visible !== e.vis || reachedBorder !== e.rb) begin
        errors++;
        $display("FAIL top_border[%0d]: got x=%0d y=%0d vis=%b rb=%b, want x=%0d y=%0d vis=%b rb=%b",
                 i, topLeftX, topLeftY, visible, reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask

  task automatic test_bottom_border();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 20, 460, 64, 20, 460, 1, 0));
    for (int k = 1; k <= 4; k++)
      st.push_back(mk(1, 1, 0, 20, 460, 64, 20, 460 + k, 1, 0));
    st.push_back(mk(1, 1, 0, 20, 460, 64, 20, 464, 0, 1));
    st.push_back(mk(0, 0, 0, 20, 460, 64, 20, 464, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      checks++;
      if (int'(topLeftX) !== e.x || int'(topLeftY) !== e.y || visible !== e.vis || reachedBorder !== e.rb) begin
        errors++;
        $display("FAIL bottom_border[%0d]: got x=%0d y=%0d vis=%b rb=%b, want x=%0d y=%0d vis=%b rb=%b",
                 i, topLeftX, topLeftY, visible, reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask

  task automatic test_fractional();
    step_t st[$];
    exp_t  e;
    int    ys[4] = '{99, 99, 98, 98};
    st.push_back(mk(0, 1, 0, 30, 100, -32, 30, 100, 1, 0));
    foreach (ys[k])
      st.push_back(mk(1, 1, 0, 30, 100, -32, 30, ys[k], 1, 0));
    st.push_back(mk(0, 0, 0, 30, 100, -32, 30, 98, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      checks++;
      if (int'(topLeftX) !== e.x || int'(topLeftY) !== e.y || visible !== e.vis || reachedBorder !== e.rb) begin
        errors++;
        $display("FAIL fractional[%0d]: got x=%0d y=%0d vis=%b rb=%b, want x=%0d y=%0d vis=%b rb=%b",
                 i, topLeftX, topLeftY, visible, reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 1, 0, 7, 200, -64, 7, 200, 1, 0)); // launch with frame: no move yet
    st.push_back(mk(1, 1, 0, 7, 200, -64, 7, 199, 1, 0));
    st.push_back(mk(1, 0, 0, 7, 200, -64, 7, 199, 0, 0)); // abort wins over frame
    st.push_back(mk(0, 0, 0, 7, 200, -64, 7, 199, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      checks++;
      if (int'(topLeftX) !== e.x || int'(topLeftY) !== e.y || visible !== e.vis || reachedBorder !== e.rb) begin
        errors++;
        $display("FAIL simultaneous[%0d]: got x=%0d y=%0d vis=%b rb=%b, want x=%0d y=%0d vis=%b rb=%b",
                 i, topLeftX, topLeftY, visible, reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask

  task automatic test_reset_midflight();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 50, 249, 64, 50, 249, 1, 0));
    st.push_back(mk(1, 1, 0, 50, 249, 64, 50, 250, 1, 0));
    st.push_back(mk(1, 1, 1, 50, 249, 64,  0,   0, 0, 0)); // reset beats frame and active
    st.push_back(mk(0, 0, 1, 50, 249, 64,  0,   0, 0, 0));
    st.push_back(mk(0, 1, 0, 50, 249, 64, 50, 249, 1, 0));
    st.push_back(mk(1, 1, 0, 50, 249, 64, 50, 250, 1, 0));
    st.push_back(mk(0, 0, 0, 50, 249, 64, 50, 250, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      checks++;
      if (int'(topLeftX) !== e.x || int'(topLeftY) !== e.y || visible !== e.vis || reachedBorder !== e.rb) begin
        errors++;
        $display("FAIL reset_midflight[%0d]: got x=%0d y=%0d vis=%b rb=%b, want x=%0d y=%0d vis=%b rb=%b",
                 i, topLeftX, topLeftY, visible, reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_launch_and_move();
    test_top_border();
    test_bottom_border();
    test_fractional();
    test_simultaneous();
    test_reset_midflight();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/single_rocket_mover.md
# single_rocket_mover

Per-rocket motion engine that sits directly downstream of the rockets controller. It consumes one `isActive` flag plus the shared `initialSpeed`/`initialX`/`initialY` launch values, integrates vertical motion once per frame in 1/64-pixel fixed point, and drives the rocket's top-left coordinate to the drawing/collision logic. It reports a one-cycle `reachedBorder` pulse back to the controller when the rocket leaves the playfield.

## Interface
Parameters:
- `ROCKET_HEIGHT`, 16: rocket sprite height in pixels.
- `SCREEN_TOP`, 0: topmost legal pixel row.
- `SCREEN_BOTTOM`, 479: bottommost legal pixel row.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse at every frame start (30 Hz).
- `isActive` in 1: level flag from the controller; a rising edge launches the rocket, a fall aborts it.
- `initialSpeed` in 9 signed: vertical speed in 1/64 px per frame, sampled at launch.
- `initialX` in 11 signed: launch X in pixels, sampled at launch.
- `initialY` in 11 signed: launch Y in pixels, sampled at launch.
- `topLeftX` out 11 signed: current rocket X in pixels.
- `topLeftY` out 11 signed: current rocket Y in pixels, the integer part of the fixed-point Y.
- `visible` out 1: high while the rocket is in flight.
- `reachedBorder` out 1: one-cycle pulse when the rocket exits the playfield.

## Operation
- States: `IDLE`, `FLYING`.
- Registers:
  - `yFP`: 17-bit signed, pixels × 64.
  - `xPix`: 11-bit.
  - `speed`: 9-bit signed.
  - `isActiveD`: 1 bit, the previous value of `isActive`.
- Launch is defined as `isActive & ~isActiveD`. It is honoured only in `IDLE`.
  - Load `xPix <= initialX`, `yFP <= initialY <<< 6`, `speed <= initialSpeed`.
  - Transition to `FLYING`.
- `FLYING` with `startOfFrame` high:
  - Compute `nextFP = yFP + sign-extended speed` in 17 bits.
  - Compute `nextY = nextFP >>> 6` (arithmetic shift, floor).
  - If `nextY < SCREEN_TOP` or `nextY + ROCKET_HEIGHT - 1 > SCREEN_BOTTOM`:
    - assert `reachedBorder` for the next cycle,
    - go to `IDLE`,
    - do not update `yFP`.
  - Otherwise set `yFP <= nextFP`.
- `FLYING` with `isActive` low (abort, e.g. alien hit): go to `IDLE` immediately, with no `reachedBorder`.
- `IDLE`: `visible = 0`. `topLeftX`/`topLeftY` hold their last values.
- `isActive` held high after exit: ignored, because there is no edge. A new launch requires `isActive` to fall and rise again.
- A re-fire while `FLYING` (new initial values with `isActive` still high) is ignored.
- Outputs:
  - `topLeftY = yFP[16:6]`.
  - `topLeftX = xPix`.
  - `visible = (state == FLYING)`.

## Timing
- Reset values: `state = IDLE`, `yFP = 0`, `xPix = 0`, `speed = 0`, `isActiveD = 0`, `topLeftX = 0`, `topLeftY = 0`, `visible = 0`, `reachedBorder = 0`.
- Launch latency: `visible` rises 1 cycle after the first cycle in which `isActive` is high.
- Motion latency: `topLeftY` reflects the new value 1 cycle after the `startOfFrame` pulse. There is at most one update per frame.
- `reachedBorder`: registered, high for exactly 1 cycle. `visible` falls in the same cycle.
- Simultaneous events:
  - `startOfFrame` together with `isActive` low: the abort wins; no move and no `reachedBorder`.
  - `startOfFrame` together with a launch edge: the launch is taken; the first move occurs on the next frame.
- Reset mid-flight: all registers return to their reset values on the next clock edge. Reset has priority over every other input.
- Out-of-range results never wrap. The 17-bit `yFP` covers −1024..1023 px, and exit is detected before any overflow.

## Structure
- Shared package `rockets_pkg`:
  - `FP_SHIFT = 6`,
  - the screen bound constants,
  - the `rocket_state_t` enum (`IDLE`, `FLYING`).
- Single module with no sub-modules. The edge detect and the fixed-point update are inline.
- Instantiated N times beside the rockets controller, one instance per `isActive` bit.

## Test plan
- Launch with `initialX = 300`, `initialY = 400`, `initialSpeed = -128`, then 1 frame.
  - Required: `visible` = 1 one cycle after `isActive` rises.
  - Required: `topLeftY` = 398 after the frame and 396 after the next frame; `topLeftX` = 300 throughout.
- Launch at `initialY = 3`, `speed = -128`.
  - Frame 1: `topLeftY` = 1.
  - Frame 2 (next Y = −1): one-cycle `reachedBorder` pulse, `visible` = 0, `topLeftY` stays 1.
- Launch at `initialY = 460`, `speed = +64`, `ROCKET_HEIGHT = 16`.
  - Frames 1–4: Y = 461, 462, 463, 464.
  - Frame 5 (Y = 465, bottom edge 480): border pulse.
- Fractional speed `-32` from Y = 100: Y reads 99, 99, 98, 98 over 4 frames, confirming floor behaviour.
- Abort and edge rules:
  - Drop `isActive` in the same cycle as `startOfFrame` mid-flight: `visible` = 0 next cycle, no pulse, Y unchanged.
  - Holding `isActive` high after a border exit: no relaunch.
- Assert `reset` mid-flight at Y = 250: the next cycle shows all outputs 0 and the state `IDLE`. A subsequent `isActive` edge relaunches normally.
